// File: rtl/branch_unit.sv
// Branch resolution unit: N/Z/C/V flag register, condition evaluation,
// registered fetch redirect and a circular return-address stack.
module branch_unit #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_we,
    input  logic              flagn_in,
    input  logic              flagz_in,
    input  logic              flagc_in,
    input  logic              flagv_in,
    input  logic              valid,
    input  logic [3:0]        jmpcond,
    input  logic              is_call,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic [ADDR_W-1:0] target,
    output logic              flagn,
    output logic              flagz,
    output logic              flagc,
    output logic              flagv,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              ret_fault,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              flagn_r;
    logic              flagz_r;
    logic              flagc_r;
    logic              flagv_r;
    logic              redirect_valid_r;
    logic [ADDR_W-1:0] redirect_pc_r;
    logic              ret_fault_r;
    logic              ras_overflow_r;
    logic [PTR_W-1:0]  sp_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] ras_r [RAS_DEPTH];

    logic              base_s;
    logic              cond_true_s;
    logic              is_ret_s;
    logic              do_jump_s;
    logic              do_push_s;
    logic              do_ret_s;
    logic              pop_ok_s;
    logic              empty_s;
    logic              full_s;
    logic [PTR_W-1:0]  sp_dec_s;
    logic [PTR_W-1:0]  sp_inc_s;
    logic [ADDR_W-1:0] top_s;

    // Base condition selected from the registered flags only.
    always_comb begin
        base_s = 1'b0;
        case (jmpcond[3:1])
            3'b000:  base_s = 1'b1;
            3'b001:  base_s = flagz_r;
            3'b010:  base_s = flagc_r;
            3'b011:  base_s = flagn_r;
            3'b100:  base_s = (flagn_r == flagv_r);
            3'b101:  base_s = (flagn_r == flagv_r) & ~flagz_r;
            3'b110:  base_s = flagc_r & ~flagz_r;
            3'b111:  base_s = 1'b1;
            default: base_s = 1'b0;
        endcase
    end

    assign cond_true_s = base_s ^ jmpcond[0];
    assign is_ret_s    = (jmpcond == 4'b1111);
    assign do_ret_s    = valid & is_ret_s;
    assign do_jump_s   = valid & ~is_ret_s & cond_true_s;
    assign do_push_s   = do_jump_s & is_call;
    assign empty_s     = (count_r == CNT_W'(1'b0));
    assign full_s      = (count_r == CNT_W'(RAS_DEPTH));
    assign pop_ok_s    = do_ret_s & ~empty_s;
    // sp_r points at the next free slot; the top entry sits one below it.
    assign sp_dec_s    = sp_r - PTR_W'(1'b1);
    assign sp_inc_s    = sp_r + PTR_W'(1'b1);
    assign top_s       = ras_r[sp_dec_s];

    // Flags, redirect outputs and return-address stack state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flagn_r          <= 1'b0;
            flagz_r          <= 1'b0;
            flagc_r          <= 1'b0;
            flagv_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
            ret_fault_r      <= 1'b0;
            ras_overflow_r   <= 1'b0;
            sp_r             <= '0;
            count_r          <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= '0;
            end
        end else begin
            if (flag_we) begin
                flagn_r <= flagn_in;
                flagz_r <= flagz_in;
                flagc_r <= flagc_in;
                flagv_r <= flagv_in;
            end

            redirect_valid_r <= 1'b0;
            ret_fault_r      <= 1'b0;
            if (do_jump_s) begin
                redirect_valid_r <= 1'b1;
                redirect_pc_r    <= target;
            end else if (pop_ok_s) begin
                redirect_valid_r <= 1'b1;
                redirect_pc_r    <= top_s;
            end else if (do_ret_s) begin
                ret_fault_r <= 1'b1;
            end

            // A push while full overwrites the oldest slot and keeps the count saturated.
            if (do_push_s) begin
                ras_r[sp_r] <= pc_next;
                sp_r        <= sp_inc_s;
                if (full_s) begin
                    ras_overflow_r <= 1'b1;
                end else begin
                    count_r <= count_r + CNT_W'(1'b1);
                end
            end else if (pop_ok_s) begin
                sp_r    <= sp_dec_s;
                count_r <= count_r - CNT_W'(1'b1);
            end
        end
    end

    assign flagn          = flagn_r;
    assign flagz          = flagz_r;
    assign flagc          = flagc_r;
    assign flagv          = flagv_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign ret_fault      = ret_fault_r;
    assign ras_overflow   = ras_overflow_r;
    assign ras_empty      = empty_s;
    assign ras_full       = full_s;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit (ADDR_W=16, RAS_DEPTH=4) with a
// reference model feeding a scoreboard of expected redirect outputs.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_we;
    logic        flagn_in, flagz_in, flagc_in, flagv_in;
    logic        valid;
    logic [3:0]  jmpcond;
    logic        is_call;
    logic [15:0] pc_next;
    logic [15:0] target;
    logic        flagn, flagz, flagc, flagv;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ret_fault;
    logic        ras_empty, ras_full, ras_overflow;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sb_q [$];
    logic [15:0] m_stack [$];
    logic [3:0]  m_flags;
    logic [15:0] m_pc;
    logic        m_ovf;

    always #5 clk = ~clk;

    branch_unit #(.ADDR_W(16), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .flagn_in(flagn_in), .flagz_in(flagz_in), .flagc_in(flagc_in), .flagv_in(flagv_in),
        .valid(valid), .jmpcond(jmpcond), .is_call(is_call),
        .pc_next(pc_next), .target(target),
        .flagn(flagn), .flagz(flagz), .flagc(flagc), .flagv(flagv),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ret_fault(ret_fault),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow)
    );

    // f = {N, Z, C, V}
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] jc);
        logic n, z, c, v, b;
        {n, z, c, v} = f;
        case (jc[3:1])
            3'd1:    b = z;
            3'd2:    b = c;
            3'd3:    b = n;
            3'd4:    b = (n == v);
            3'd5:    b = (n == v) && !z;
            3'd6:    b = c && !z;
            default: b = 1'b1;
        endcase
        return b ^ jc[0];
    endfunction

    task automatic check_outputs(input string tag);
        logic [17:0] exp_v;
        logic [17:0] got_v;
        logic [6:0]  exp_s;
        logic [6:0]  got_s;
        exp_v = sb_q.pop_front();
        got_v = {redirect_valid, redirect_pc, ret_fault};
        checks++;
        assert (got_v === exp_v) else begin
            failures++;
            $error("FAIL %s redirect got=%h exp=%h", tag, got_v, exp_v);
        end
        exp_s = {(m_stack.size() == 0), (m_stack.size() == 4), m_ovf, m_flags};
        got_s = {ras_empty, ras_full, ras_overflow, flagn, flagz, flagc, flagv};
        checks++;
        assert (got_s === exp_s) else begin
            failures++;
            $error("FAIL %s status got=%b exp=%b", tag, got_s, exp_s);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] jc, input logic call,
                        input logic [15:0] pcn, input logic [15:0] tgt,
                        input logic fw, input logic [3:0] fv, input string tag);
        logic rv, rf;
        valid   = v;
        jmpcond = jc;
        is_call = call;
        pc_next = pcn;
        target  = tgt;
        flag_we = fw;
        {flagn_in, flagz_in, flagc_in, flagv_in} = fv;
        rv = 1'b0;
        rf = 1'b0;
        if (v && jc == 4'hF) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
                rv   = 1'b1;
            end else begin
                rf = 1'b1;
            end
        end else if (v && ref_cond(m_flags, jc)) begin
            rv   = 1'b1;
            m_pc = tgt;
            if (call) begin
                if (m_stack.size() == 4) begin
                    m_stack.delete(0);
                    m_ovf = 1'b1;
                end
                m_stack.push_back(pcn);
            end
        end
        if (fw) m_flags = fv;
        sb_q.push_back({rv, m_pc, rf});
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // A branch and a flag write are held during reset; both must be discarded.
    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        valid   = 1'b1;
        jmpcond = 4'h0;
        is_call = 1'b1;
        pc_next = 16'h0BAD;
        target  = 16'h1234;
        flag_we = 1'b1;
        {flagn_in, flagz_in, flagc_in, flagv_in} = 4'hF;
        m_stack.delete();
        m_flags = 4'h0;
        m_pc    = 16'h0000;
        m_ovf   = 1'b0;
        sb_q.push_back({1'b0, 16'h0000, 1'b0});
        @(posedge clk);
        #1;
        check_outputs(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0; jmpcond = 4'h0; is_call = 1'b0; pc_next = 16'h0; target = 16'h0;
        flag_we = 1'b0; {flagn_in, flagz_in, flagc_in, flagv_in} = 4'h0;
        @(posedge clk);
        #1;
        do_reset("reset");
        step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, "post_reset_idle");

        // Condition table sweep; the stack is empty so 1111 must fault.
        for (int f = 0; f < 16; f++) begin
            step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1, 4'(f), "flag_load");
            for (int j = 0; j < 16; j++) begin
                step(1'b1, 4'(j), 1'b0, 16'h0, {4'(f), 4'(j), 8'h5A}, 1'b0, 4'h0, "cond_sweep");
            end
        end

        // Flag timing: new Z is not visible to a branch in the same cycle.
        step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1, 4'h0, "ft_clear");
        step(1'b1, 4'b0010, 1'b0, 16'h0, 16'h0300, 1'b1, 4'b0100, "ft_same_cycle");
        step(1'b1, 4'b0010, 1'b0, 16'h0, 16'h0300, 1'b0, 4'h0, "ft_next_cycle");

        // Call then return.
        step(1'b1, 4'h0, 1'b1, 16'h0104, 16'h0200, 1'b0, 4'h0, "call");
        step(1'b1, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, "return");
        step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, "cr_idle");

        // Overflow: five calls into a 4-deep stack, then five returns.
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 4'h0, 1'b1, 16'(k * 16), 16'(16'h1000 + k), 1'b0, 4'h0, "ovf_call");
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'hF, 1'b1, 16'hFFFF, 16'hEEEE, 1'b0, 4'h0, "ovf_return");
        end
        step(1'b0, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, "invalid_return");

        // Reset mid-operation clears stack and overflow.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'h0, 1'b1, 16'(16'h0700 + k), 16'(16'h0800 + k), 1'b0, 4'h0, "pre_reset_push");
        end
        do_reset("mid_reset");
        step(1'b1, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0, "return_after_reset");

        // Back-to-back mixed traffic, one branch every cycle.
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 "b2b");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
